pippo_div_seq: RTL

//  Issue/completion sequencer around the pipelined 64/32 unsigned divider (pippo_div_uu).

---
 rtl/pippo_div_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pippo_div_seq.sv
// Issue/completion sequencer wrapped around the pipelined 64/32 unsigned divider.
// Optional rsp_dz output enabled by defining PIPPO_DIV_DZ_FLAG_EN.
module pippo_div_seq #(
  parameter int D_WIDTH = 32,
  parameter int TAG_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [D_WIDTH-1:0]   req_a,
  input  logic [D_WIDTH-1:0]   req_b,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 div_ena,
  output logic [2*D_WIDTH-1:0] div_z,
  output logic [D_WIDTH-1:0]   div_d,
  input  logic [D_WIDTH-1:0]   div_q,
  input  logic [D_WIDTH-1:0]   div_s,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [D_WIDTH-1:0]   rsp_data,
  output logic [TAG_W-1:0]     rsp_tag
`ifdef PIPPO_DIV_DZ_FLAG_EN
  ,
  output logic                 rsp_dz
`endif
);
  localparam int LAT = D_WIDTH + 1;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic               rem;
    logic               qneg;
    logic               rneg;
    logic               dz;
    logic [D_WIDTH-1:0] a;
  } shadow_t;

  logic               issue, sgn, a_neg, b_neg, cap;
  logic [D_WIDTH-1:0] a_mag, b_mag, res;
  shadow_t            sh_in, tail;
  shadow_t [LAT:1]    sh_q;
  logic    [LAT:1]    vld_pipe_q;

  logic               rsp_valid_q, rsp_valid_d;
  logic [D_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

  assign div_ena   = ~rsp_valid_q | rsp_ready;
  assign req_ready = div_ena & ~flush;
  assign issue     = req_valid & req_ready;

  // DIV/REM (op[0]==0) are signed: the divider only ever sees magnitudes.
  assign sgn   = ~req_op[0];
  assign a_neg = sgn & req_a[D_WIDTH-1];
  assign b_neg = sgn & req_b[D_WIDTH-1];
  assign a_mag = a_neg ? -req_a : req_a;
  assign b_mag = b_neg ? -req_b : req_b;
  assign div_z = issue ? {{D_WIDTH{1'b0}}, a_mag} : '0;
  assign div_d = issue ? b_mag : '0;

  always_comb begin
    sh_in      = '0;
    sh_in.tag  = req_tag;
    sh_in.rem  = req_op[1];
    sh_in.qneg = a_neg ^ b_neg;
    sh_in.rneg = a_neg;
    sh_in.dz   = (req_b == '0);
    sh_in.a    = req_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      sh_q       <= '0;
    end else begin
      if (flush)        vld_pipe_q <= '0;
      else if (div_ena) vld_pipe_q <= {vld_pipe_q[LAT-1:1], issue};
      if (div_ena)      sh_q       <= {sh_q[LAT-1:1], sh_in};
    end
  end

  // Sign and divide-by-zero fix-up on the op leaving the divider.
  assign tail = sh_q[LAT];
  assign cap  = vld_pipe_q[LAT] & div_ena;

  always_comb begin
    res = '0;
    if (tail.rem) res = tail.dz ? tail.a : (tail.rneg ? -div_s : div_s);
    else          res = tail.dz ? '1     : (tail.qneg ? -div_q : div_q);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (cap) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = res;
      rsp_tag_d   = tail.tag;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

`ifdef PIPPO_DIV_DZ_FLAG_EN
  logic rsp_dz_q, rsp_dz_d;

  always_comb begin
    rsp_dz_d = rsp_dz_q;
    if (flush)    rsp_dz_d = 1'b0;
    else if (cap) rsp_dz_d = tail.dz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_dz_q <= 1'b0;
    else        rsp_dz_q <= rsp_dz_d;
  end

  assign rsp_dz = rsp_dz_q;
`endif

endmodule
